// File: rtl/exec_unit.sv
`default_nettype none
// exec_unit: single-issue ALU with valid/ready handshakes. Defining EXEC_UNIT_MULDIV_EN
// adds iterative MUL/MULHU/DIVU/REMU (one bit per cycle); otherwise ops 10-13 report err.
module exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [3:0]      op_reg;
    logic [XLEN-1:0] a_reg, b_reg;
    logic            accept;
    logic            start_calc;
    logic            calc_last;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = start_calc ? CALC : DONE;
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg <= 4'd0;
            a_reg  <= '0;
            b_reg  <= '0;
        end else if (accept) begin
            op_reg <= op;
            a_reg  <= a;
            b_reg  <= b;
        end
    end

`ifdef EXEC_UNIT_MULDIV_EN
    // hi/lo hold product-high/product-low for MUL, remainder/quotient for DIV.
    logic [SHW-1:0]  count;
    logic [XLEN-1:0] hi, lo;
    logic [XLEN-1:0] hi_step, lo_step;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            div_ge;

    assign start_calc = (op >= 4'd10) && (op <= 4'd13);
    assign calc_last  = (count == '0);

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_ge    = (div_shift >= {1'b0, b_reg});
        if (op_reg[2]) begin
            hi_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_step = mul_sum[XLEN:1];
            lo_step = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Divide by zero needs no special case: every trial subtract succeeds,
    // giving an all-ones quotient and leaving the dividend as remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (accept && start_calc) begin
            count <= SHW'(XLEN - 1);
            hi    <= '0;
            lo    <= op[2] ? a : b;
        end else if (state == CALC) begin
            count <= count - SHW'(1);
            hi    <= hi_step;
            lo    <= lo_step;
        end
    end
`else
    assign start_calc = 1'b0;
    assign calc_last  = 1'b1;
`endif

    logic signed [XLEN-1:0] sra_res;
    assign sra_res = $signed(a_reg) >>> b_reg[SHW-1:0];

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op_reg)
            4'd0: result = a_reg & b_reg;
            4'd1: result = a_reg | b_reg;
            4'd2: result = a_reg + b_reg;
            4'd3: result = a_reg << b_reg[SHW-1:0];
            4'd4: result = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            4'd5: result = {{(XLEN-1){1'b0}}, (a_reg < b_reg)};
            4'd6: result = a_reg - b_reg;
            4'd7: result = a_reg ^ b_reg;
            4'd8: result = a_reg >> b_reg[SHW-1:0];
            4'd9: result = sra_res;
`ifdef EXEC_UNIT_MULDIV_EN
            4'd10: result = lo;
            4'd11: result = hi;
            4'd12: result = lo;
            4'd13: result = hi;
`endif
            default: err = 1'b1;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_exec_unit.sv
`default_nettype none
// Self-checking bench for exec_unit (XLEN=32) against an arithmetic reference model.
module tb_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a, b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            err;

    int checks   = 0;
    int failures = 0;

    exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the operation definitions, using plain arithmetic.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic er, output int lat);
        longint unsigned prod;
        int              sx;
        logic [4:0]      sh;
        sh   = y[4:0];
        sx   = int'(x);
        prod = longint'(x) * longint'(y);
        er   = 1'b0;
        lat  = 1;
        res  = 32'd0;
        case (o)
            4'd0: res = x & y;
            4'd1: res = x | y;
            4'd2: res = x + y;
            4'd3: res = x << sh;
            4'd4: res = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            4'd5: res = (x < y) ? 32'd1 : 32'd0;
            4'd6: res = x - y;
            4'd7: res = x ^ y;
            4'd8: res = x >> sh;
            4'd9: res = 32'(sx >>> sh);
`ifdef EXEC_UNIT_MULDIV_EN
            4'd10: begin res = prod[31:0];  lat = XLEN + 1; end
            4'd11: begin res = prod[63:32]; lat = XLEN + 1; end
            4'd12: begin res = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = XLEN + 1; end
            4'd13: begin res = (y == 0) ? x : x % y;             lat = XLEN + 1; end
`endif
            default: er = 1'b1;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int hold,
                          input bit has_spec, input logic [31:0] spec_res);
        logic [31:0] m_res;
        logic        m_err;
        int          m_lat;
        int          lat;
        logic [31:0] held;
        model(o, x, y, m_res, m_err, m_lat);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, m_lat);
        check({tag, "_result"}, result, m_res);
        check({tag, "_err"}, err, m_err);
        if (has_spec) check({tag, "_spec_result"}, result, spec_res);
        held = result;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check({tag, "_hold_result"}, result, held);
            check({tag, "_hold_valid"}, out_valid, 1);
        end
        in_valid = 1'b0;
        check({tag, "_busy_in_ready"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_retired"}, out_valid, 0);
        check({tag, "_ready_again"}, in_ready, 1);
    endtask

    initial begin
        bit seen;
        reset = 1'b1; in_valid = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 0);
        check("reset_err", err, 0);
        in_valid = 1'b0;
        reset = 1'b0;

        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd2, 0, 1, 32'h0000_0001);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0024, 0, 1, 32'hF800_0000);
        run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd1);
        run_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 0, 1, 32'd0);
`ifdef EXEC_UNIT_MULDIV_EN
        run_op("mul", 4'd10, 32'h0001_0000, 32'h0001_0000, 0, 1, 32'd0);
        run_op("mulhu", 4'd11, 32'h0001_0000, 32'h0001_0000, 0, 1, 32'd1);
        run_op("divu", 4'd12, 32'd100, 32'd7, 0, 1, 32'd14);
        run_op("remu", 4'd13, 32'd100, 32'd7, 0, 1, 32'd2);
        run_op("divu_zero", 4'd12, 32'd5, 32'd0, 0, 1, 32'hFFFF_FFFF);
        run_op("remu_zero", 4'd13, 32'd5, 32'd0, 0, 1, 32'd5);
`else
        run_op("mul_off", 4'd10, 32'h0001_0000, 32'h0001_0000, 0, 1, 32'd0);
        run_op("remu_off", 4'd13, 32'd100, 32'd7, 0, 1, 32'd0);
`endif
        run_op("backpressure", 4'd6, 32'd10, 32'd3, 5, 1, 32'd7);
        run_op("op14", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 32'd0);
        run_op("op15", 4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'd0);

        // Reset asserted between edges ten cycles into a DIVU.
        in_valid = 1'b1; op = 4'd12; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midcalc_reset_out_valid", out_valid, 0);
        check("midcalc_reset_in_ready", in_ready, 1);
        check("midcalc_reset_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("discarded_op_not_reported", seen, 0);
        run_op("add_after_reset", 4'd2, 32'd3, 32'd4, 0, 1, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op("random", 4'($urandom_range(0, 15)), ra, rb, $urandom_range(0, 2), 0, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), meaning shift-amount width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept an operation.
REQ-007 SHALL have port op  input  4  operation code.
REQ-008 SHALL have port a  input  XLEN  first operand.
REQ-009 SHALL have port b  input  XLEN  second operand.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port err  output  1  unsupported op flag, qualified by out_valid.

Function
REQ-014 SHALL decode op codes: 0 AND, 1 OR, 2 ADD, 3 SLL, 4 SLT, 5 SLTU, 6 SUB, 7 XOR, 8 SRL, 9 SRA, 10 MUL (low XLEN bits), 11 MULHU (high XLEN bits, unsigned), 12 DIVU, 13 REMU; 14/15 are unsupported.
REQ-015 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; accept occurs when in_valid and in_ready are both 1 at a rising edge; a and b are captured into internal registers at acceptance.
REQ-017 SHALL complete ops 0-9 and 14-15 in one step: IDLE->DONE, out_valid asserted the cycle after acceptance (latency 1).
REQ-018 SHALL execute ops 10-13 iteratively in CALC, one bit per cycle, over XLEN cycles using a down-counter loaded with XLEN-1; CALC->DONE when counter=0 (latency XLEN+1).
REQ-019 SHALL compute SLT as signed and SLTU as unsigned compare (result 1 or 0); shifts use b[SHW-1:0] only; SRA replicates a[XLEN-1].
REQ-020 SHALL wrap ADD/SUB/MUL results modulo 2^XLEN, with no overflow flag.
REQ-021 SHALL return all-ones for DIVU by zero and a for REMU by zero, still taking XLEN+1 cycles.
REQ-022 SHALL return result=0 and err=1 for unsupported ops; err=0 otherwise.
REQ-023 SHALL hold result, err and out_valid stable in DONE until out_ready=1; DONE->IDLE on out_valid and out_ready.
REQ-024 SHALL keep in_ready=0 in the cycle of result acceptance; a new op is accepted no earlier than the following cycle (no same-cycle accept/retire).
REQ-025 SHALL ignore in_valid, op, a and b while in CALC or DONE.

Reset
REQ-026 SHALL, on reset assertion, immediately force state IDLE, in_ready=1, out_valid=0, result=0, err=0, counter=0 and clear operand registers, including mid-CALC; the interrupted op is discarded and never reported.
REQ-027 SHALL accept no operation while reset is high; the first accept is possible on the first rising edge after deassertion.

Configuration
REQ-028 SHALL use macro EXEC_UNIT_MULDIV_EN: when defined, ops 10-13 behave per REQ-018/021; when undefined, ops 10-13 are unsupported (latency 1, result=0, err=1), and no CALC datapath or counter is synthesised.

Verification
REQ-029 SHALL verify ADD a=0xFFFFFFFF, b=2 -> result 0x00000001, err=0, out_valid one cycle after accept.
REQ-030 SHALL verify SRA a=0x80000000, b=0x00000024 (shamt 4) -> 0xF8000000; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0.
REQ-031 SHALL verify with MULDIV_EN that MUL a=0x10000, b=0x10000 returns 0 while MULHU returns 1, each 33 cycles after accept; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF.
REQ-032 SHALL verify backpressure: out_ready held 0 for 5 cycles after DONE -> result stable, in_ready=0, then retires on out_ready=1 and in_ready=1 the next cycle.
REQ-033 SHALL verify that reset asserted at cycle 10 of a DIVU -> out_valid=0 and in_ready=1 immediately, and that a following ADD 3+4 -> 7.
REQ-034 SHALL verify op=14 -> err=1, result=0, as well as op=10 without MULDIV_EN -> err=1, latency 1.
